// File: rtl/regfile_2r1w.sv
// DEPTH x WIDTH register bank with one byte-lane-masked write port and two
// registered, write-first read ports; entry 0 optionally hardwired to zero.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_arstn,
  input  logic               i_srstn,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [WIDTH/8-1:0] i_wbe,
  input  logic [AW-1:0]      i_raddr_a,
  input  logic [AW-1:0]      i_raddr_b,
  output logic [WIDTH-1:0]   o_rdata_a,
  output logic [WIDTH-1:0]   o_rdata_b
);

  localparam int          NB        = WIDTH / 8;
  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_addr_ok;
  logic             rd_a_ok;
  logic             rd_b_ok;
  logic             wr_hit;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_a_nxt;
  logic [WIDTH-1:0] rd_b_nxt;

  // An address is live only if it is in range and not the hardwired-zero entry.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_LIM) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_addr_ok = addr_live(i_waddr);
  assign rd_a_ok    = addr_live(i_raddr_a);
  assign rd_b_ok    = addr_live(i_raddr_b);
  assign wr_hit     = i_we && (|i_wbe) && wr_addr_ok;

  always_comb begin
    wr_old    = '0;
    if (wr_addr_ok) wr_old = mem[i_waddr];
    wr_merged = wr_old;
    for (int k = 0; k < NB; k++) begin
      if (i_wbe[k]) wr_merged[8*k +: 8] = i_wdata[8*k +: 8];
    end
  end

  // Write-first: a same-edge write to the read address is forwarded merged.
  always_comb begin
    rd_a_nxt = '0;
    rd_b_nxt = '0;
    if (rd_a_ok) begin
      if (wr_hit && (i_raddr_a == i_waddr)) rd_a_nxt = wr_merged;
      else                                  rd_a_nxt = mem[i_raddr_a];
    end
    if (rd_b_ok) begin
      if (wr_hit && (i_raddr_b == i_waddr)) rd_b_nxt = wr_merged;
      else                                  rd_b_nxt = mem[i_raddr_b];
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      o_rdata_a <= '0;
      o_rdata_b <= '0;
    end else if (!i_srstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      o_rdata_a <= '0;
      o_rdata_b <= '0;
    end else begin
      if (wr_hit) mem[i_waddr] <= wr_merged;
      o_rdata_a <= rd_a_nxt;
      o_rdata_b <= rd_b_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a 32-bit/20-entry zero-reg instance and a
// 64-bit/8-entry instance without zero reg, checked through an expectation queue.
module tb_regfile_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arstn;

  logic        s_srstn, s_we;
  logic [4:0]  s_waddr, s_ra, s_rb;
  logic [31:0] s_wdata, s_rda, s_rdb;
  logic [3:0]  s_wbe;

  logic        w_srstn, w_we;
  logic [2:0]  w_waddr, w_ra, w_rb;
  logic [63:0] w_wdata, w_rda, w_rdb;
  logic [7:0]  w_wbe;

  regfile_2r1w #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1)) u32 (
    .i_clk(clk), .i_arstn(arstn), .i_srstn(s_srstn), .i_we(s_we),
    .i_waddr(s_waddr), .i_wdata(s_wdata), .i_wbe(s_wbe),
    .i_raddr_a(s_ra), .i_raddr_b(s_rb), .o_rdata_a(s_rda), .o_rdata_b(s_rdb));

  regfile_2r1w #(.WIDTH(64), .DEPTH(8), .ZERO_REG(1'b0)) u64 (
    .i_clk(clk), .i_arstn(arstn), .i_srstn(w_srstn), .i_we(w_we),
    .i_waddr(w_waddr), .i_wdata(w_wdata), .i_wbe(w_wbe),
    .i_raddr_a(w_ra), .i_raddr_b(w_rb), .o_rdata_a(w_rda), .o_rdata_b(w_rdb));

  typedef struct {
    string       name;
    logic        srstn;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] rm [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic srstn, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wbe, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.name = name; v.srstn = srstn; v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.wbe = wbe; v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic apply32(input string name, input logic srstn, input logic we,
                         input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wbe, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    s_srstn = srstn; s_we = we; s_waddr = waddr; s_wdata = wdata; s_wbe = wbe;
    s_ra = ra; s_rb = rb;
    e.name = name; e.a = {32'h0, ea}; e.b = {32'h0, eb};
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_a"}, {32'h0, s_rda}, e.a);
      check({e.name, "_b"}, {32'h0, s_rdb}, e.b);
    end
  endtask

  task automatic apply64(input string name, input logic we, input logic [2:0] waddr,
                         input logic [63:0] wdata, input logic [7:0] wbe,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic [63:0] ea, input logic [63:0] eb);
    exp_t e;
    w_srstn = 1'b1; w_we = we; w_waddr = waddr; w_wdata = wdata; w_wbe = wbe;
    w_ra = ra; w_rb = rb;
    e.name = name; e.a = ea; e.b = eb;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.name, "_a"}, w_rda, e.a);
      check({e.name, "_b"}, w_rdb, e.b);
    end
  endtask

  function automatic logic [31:0] exp_entry(input int a);
    case (a)
      3:       return 32'h12345678;
      4:       return 32'h00000077;
      5:       return 32'hDEADBEEF;
      7:       return 32'hAA22CC44;
      9:       return 32'h00000055;
      12:      return 32'hCAFEF00D;
      19:      return 32'hA5000000;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    arstn = 1'b1;
    s_srstn = 1'b1; s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_wbe = '0; s_ra = '0; s_rb = '0;
    w_srstn = 1'b1; w_we = 1'b0; w_waddr = '0; w_wdata = '0; w_wbe = '0; w_ra = '0; w_rb = '0;
    #1 arstn = 1'b0;
    #2;
    check("rst_u32_a", {32'h0, s_rda}, 64'h0);
    check("rst_u32_b", {32'h0, s_rdb}, 64'h0);
    check("rst_u64_a", w_rda, 64'h0);
    check("rst_u64_b", w_rdb, 64'h0);
    @(negedge clk); @(negedge clk);
    arstn = 1'b1;

    //      name       srst we  wa     wdata          wbe    ra     rb     exp_a          exp_b
    add_vec("w3",      1, 1, 5'd3,  32'h12345678, 4'hF, 5'd1,  5'd2,  32'h0,        32'h0);
    add_vec("rd3b",    1, 0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd3,  32'h0,        32'h12345678);
    add_vec("w7",      1, 1, 5'd7,  32'hAABBCCDD, 4'hF, 5'd3,  5'd7,  32'h12345678, 32'hAABBCCDD);
    add_vec("be_byp",  1, 1, 5'd7,  32'h11223344, 4'h5, 5'd7,  5'd3,  32'hAA22CC44, 32'h12345678);
    add_vec("rd7",     1, 0, 5'd0,  32'h0,        4'h0, 5'd7,  5'd7,  32'hAA22CC44, 32'hAA22CC44);
    add_vec("w0",      1, 1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0,  5'd1,  32'h0,        32'h0);
    add_vec("w25",     1, 1, 5'd25, 32'hFFFFFFFF, 4'hF, 5'd25, 5'd0,  32'h0,        32'h0);
    add_vec("wbe0",    1, 1, 5'd3,  32'hFFFFFFFF, 4'h0, 5'd3,  5'd7,  32'h12345678, 32'hAA22CC44);
    add_vec("we0",     1, 0, 5'd3,  32'h0,        4'hF, 5'd3,  5'd19, 32'h12345678, 32'h0);
    add_vec("w19",     1, 1, 5'd19, 32'hA5A5A5A5, 4'h8, 5'd19, 5'd18, 32'hA5000000, 32'h0);
    add_vec("w12",     1, 1, 5'd12, 32'hCAFEF00D, 4'hF, 5'd1,  5'd2,  32'h0,        32'h0);
    add_vec("dual12",  1, 0, 5'd0,  32'h0,        4'h0, 5'd12, 5'd12, 32'hCAFEF00D, 32'hCAFEF00D);
    add_vec("w4",      1, 1, 5'd4,  32'h00000077, 4'hF, 5'd4,  5'd9,  32'h00000077, 32'h0);
    add_vec("w5",      1, 1, 5'd5,  32'hDEADBEEF, 4'hF, 5'd5,  5'd4,  32'hDEADBEEF, 32'h00000077);
    add_vec("w9_l0",   1, 1, 5'd9,  32'h00000055, 4'h1, 5'd3,  5'd9,  32'h12345678, 32'h00000055);

    for (int i = 0; i < tbl.size(); i++)
      apply32(tbl[i].name, tbl[i].srstn, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].wbe,
              tbl[i].ra, tbl[i].rb, tbl[i].ea, tbl[i].eb);

    // Sweep every address, including out-of-range ones, on both ports.
    for (int a = 0; a < 32; a++)
      apply32("sweep", 1, 0, 5'd0, 32'h0, 4'h0, 5'(a), 5'(31 - a),
              exp_entry(a), exp_entry(31 - a));

    // Async reset between edges, with a write pending on the inputs.
    apply32("pre_arst", 1, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd3, 32'hDEADBEEF, 32'h12345678);
    s_we = 1'b1; s_waddr = 5'd5; s_wdata = 32'h12121212; s_wbe = 4'hF;
    #3 arstn = 1'b0;
    #1;
    check("arst_async_a", {32'h0, s_rda}, 64'h0);
    check("arst_async_b", {32'h0, s_rdb}, 64'h0);
    s_we = 1'b0;
    @(negedge clk); @(negedge clk);
    arstn = 1'b1;
    apply32("arst_rd5", 1, 0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd3, 32'h0, 32'h0);

    // Sync clear beats a coincident write.
    apply32("sc_w4",   1, 1, 5'd4, 32'h00000077, 4'hF, 5'd4, 5'd0, 32'h00000077, 32'h0);
    apply32("sc_w9",   1, 1, 5'd9, 32'h000000AB, 4'hF, 5'd9, 5'd4, 32'h000000AB, 32'h00000077);
    apply32("sclr",    0, 1, 5'd9, 32'h00000055, 4'hF, 5'd9, 5'd4, 32'h0, 32'h0);
    apply32("post_sc", 1, 0, 5'd0, 32'h0,        4'h0, 5'd9, 5'd4, 32'h0, 32'h0);

    // Random traffic against a behavioural model; state is all zero here.
    for (int j = 0; j < 20; j++) rm[j] = 32'h0;
    for (int i = 0; i < 300; i++) begin
      logic        r_srstn, r_we;
      logic [4:0]  r_wa, r_ra, r_rb;
      logic [31:0] r_wd, r_ea, r_eb;
      logic [3:0]  r_be;
      r_srstn = ($urandom_range(0, 15) != 0);
      r_we    = 1'($urandom_range(0, 1));
      r_wa    = 5'($urandom_range(0, 31));
      r_wd    = $urandom;
      r_be    = 4'($urandom_range(0, 15));
      r_ra    = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      r_rb    = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
      if (!r_srstn) begin
        for (int j = 0; j < 20; j++) rm[j] = 32'h0;
        r_ea = 32'h0;
        r_eb = 32'h0;
      end else begin
        if (r_we && (r_be != 4'h0) && (r_wa < 5'd20) && (r_wa != 5'd0))
          for (int k = 0; k < 4; k++)
            if (r_be[k]) rm[int'(r_wa)][8*k +: 8] = r_wd[8*k +: 8];
        r_ea = ((r_ra < 5'd20) && (r_ra != 5'd0)) ? rm[int'(r_ra)] : 32'h0;
        r_eb = ((r_rb < 5'd20) && (r_rb != 5'd0)) ? rm[int'(r_rb)] : 32'h0;
      end
      apply32("rand", r_srstn, r_we, r_wa, r_wd, r_be, r_ra, r_rb, r_ea, r_eb);
    end
    s_we = 1'b0; s_srstn = 1'b1;

    // 64-bit instance: lower-lane-only update and a writable entry 0.
    apply64("w64_full", 1, 3'd6, 64'h1122334455667788, 8'hFF, 3'd6, 3'd0,
            64'h1122334455667788, 64'h0);
    apply64("w64_lo",   1, 3'd6, 64'hCAFEF00DCAFEF00D, 8'h0F, 3'd6, 3'd6,
            64'h11223344CAFEF00D, 64'h11223344CAFEF00D);
    apply64("r64",      0, 3'd0, 64'h0, 8'h00, 3'd6, 3'd6,
            64'h11223344CAFEF00D, 64'h11223344CAFEF00D);
    apply64("w64_z",    1, 3'd0, 64'h0123456789ABCDEF, 8'hF0, 3'd0, 3'd6,
            64'h0123456700000000, 64'h11223344CAFEF00D);
    apply64("r64_z",    0, 3'd0, 64'h0, 8'h00, 3'd0, 3'd7,
            64'h0123456700000000, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
